frame_buff_wr_ctrl: RTL

Write-side sequencer for the 128x128 RGB444 frame buffer. Accepts the camera's byte-serial RGB565 stream (VSYNC/HREF/byte-valid, already synchronised to `clk`), crops a centred 128x128 window out of the 320x240 QVGA source, and packs each pixel to 12 bits. It drives the buffer's write port (`wea`/`addra`/`dina`) and sequences single-shot or continuous frame captures, so the display side reads only whole frames.

---
 rtl/frame_buff_pkg.sv | 31 +++
 rtl/cam_edge_det.sv | 29 ++
 rtl/frame_buff_wr_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/frame_buff_pkg.sv
// Shared definitions for the 128x128 RGB444 frame buffer write side:
// default source/window geometry, buffer word width, FSM state encoding
// and the RGB565 -> RGB444 packing function.
package frame_buff_pkg;

  // Default geometry: centred 128x128 window inside a 320x240 QVGA frame.
  localparam int SRC_COLS = 320;
  localparam int SRC_ROWS = 240;
  localparam int IMG_COLS = 128;
  localparam int IMG_ROWS = 128;
  localparam int COL_OFS  = 96;
  localparam int ROW_OFS  = 56;
  localparam int NB_ADDR  = 14;

  // Buffer word: R4 G4 B4.
  localparam int C_NB_BUF = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_SYNC    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  // Camera sends RRRRRGGG then GGGBBBBB; keep the top bits of each channel.
  function automatic logic [C_NB_BUF-1:0] rgb565_to_444(input logic [7:0] b_hi,
                                                        input logic [7:0] b_lo);
    return {b_hi[7:4], b_hi[2:0], b_lo[7], b_lo[4:1]};
  endfunction

endpackage

// File: rtl/cam_edge_det.sv
// Registered edge detector for a camera sync line already in the clk domain.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   sig       - level input
//   rise/fall - one-cycle pulses, valid in the cycle the new level is seen
module cam_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      // NOTE: non-blocking for every flop so all registers update from
      // pre-edge values regardless of block ordering.
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule

// File: rtl/frame_buff_wr_ctrl.sv
// Write-side sequencer for the RGB444 frame buffer. Takes the byte-serial
// RGB565 camera stream, crops a window out of the source frame, packs each
// pixel to 12 bits and writes it to the buffer. Captures are single-shot
// (armed by start) or continuous (cfg_cont), always starting on a frame
// boundary so the reader only ever sees whole frames.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   cam_vsync/href/bvld/byte  - camera stream (already clk-synchronous)
//   cfg_cont, start           - capture mode and arm pulse
//   wea, addra, dina          - buffer write port
//   busy                      - armed or capturing
//   frame_done, frame_err     - frame complete / aborted pulses
//   frame_cnt                 - completed frames, wrapping
module frame_buff_wr_ctrl
  import frame_buff_pkg::*;
#(
  parameter int C_SRC_COLS = SRC_COLS,
  parameter int C_SRC_ROWS = SRC_ROWS,
  parameter int C_IMG_COLS = IMG_COLS,
  parameter int C_IMG_ROWS = IMG_ROWS,
  parameter int C_COL_OFS  = COL_OFS,
  parameter int C_ROW_OFS  = ROW_OFS,
  parameter int C_NB_ADDR  = NB_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cam_vsync,
  input  logic                 cam_href,
  input  logic                 cam_bvld,
  input  logic [7:0]           cam_byte,
  input  logic                 cfg_cont,
  input  logic                 start,
  output logic                 wea,
  output logic [C_NB_ADDR-1:0] addra,
  output logic [C_NB_BUF-1:0]  dina,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic [7:0]           frame_cnt
);

  localparam int COL_W = $clog2(C_SRC_COLS + 1);
  localparam int ROW_W = $clog2(C_SRC_ROWS + 1);

  localparam logic [COL_W-1:0]     COL_LO    = COL_W'(C_COL_OFS);
  localparam logic [COL_W-1:0]     COL_HI    = COL_W'(C_COL_OFS + C_IMG_COLS);
  localparam logic [ROW_W-1:0]     ROW_LO    = ROW_W'(C_ROW_OFS);
  localparam logic [ROW_W-1:0]     ROW_HI    = ROW_W'(C_ROW_OFS + C_IMG_ROWS);
  localparam logic [C_NB_ADDR-1:0] LAST_ADDR = C_NB_ADDR'(C_IMG_COLS * C_IMG_ROWS - 1);

  state_t state, state_nxt;

  logic vs_rise, vs_fall, hr_rise, hr_fall;

  logic [COL_W-1:0]     src_col;
  logic [ROW_W-1:0]     src_row;
  logic                 phase;
  logic [7:0]           byte_hi;
  logic [C_NB_ADDR-1:0] wr_addr;

  logic byte_ok, phase_eff, in_win, pix_wr, last_wr;

  cam_edge_det u_vs_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (cam_vsync),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  cam_edge_det u_hr_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (cam_href),
    .rise (hr_rise),
    .fall (hr_fall)
  );

  // A byte only counts while the line is valid; a strobe coinciding with the
  // href falling edge has href low and is dropped here.
  assign byte_ok   = (state == ST_CAPTURE) && cam_bvld && cam_href;
  // Every line starts on a high byte, whatever phase was left behind.
  assign phase_eff = hr_rise ? 1'b0 : phase;
  assign in_win    = (src_row >= ROW_LO) && (src_row < ROW_HI) &&
                     (src_col >= COL_LO) && (src_col < COL_HI);
  assign pix_wr    = byte_ok && phase_eff && in_win;
  assign last_wr   = pix_wr && (wr_addr == LAST_ADDR);

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start || cfg_cont) state_nxt = ST_WAIT_VS;
      // Level check: only arm once blanking is seen, never mid-frame.
      ST_WAIT_VS: if (cam_vsync) state_nxt = ST_SYNC;
      ST_SYNC:    if (vs_fall) state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        if (last_wr)      state_nxt = cfg_cont ? ST_WAIT_VS : ST_IDLE;
        else if (vs_rise) state_nxt = cfg_cont ? ST_SYNC : ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_col    <= '0;
      src_row    <= '0;
      phase      <= 1'b0;
      byte_hi    <= '0;
      wr_addr    <= '0;
      wea        <= 1'b0;
      addra      <= '0;
      dina       <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      wea        <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      // Counters are held clear outside CAPTURE, so entering CAPTURE on the
      // vsync falling edge always starts at row 0, column 0, address 0.
      if (state != ST_CAPTURE) begin
        src_col <= '0;
        src_row <= '0;
        phase   <= 1'b0;
        wr_addr <= '0;
      end else if (hr_fall) begin
        // Line end; an odd trailing high byte is simply forgotten.
        src_col <= '0;
        src_row <= src_row + 1'b1;
        phase   <= 1'b0;
      end else if (byte_ok) begin
        phase <= ~phase_eff;
        if (!phase_eff) begin
          byte_hi <= cam_byte;
        end else begin
          src_col <= src_col + 1'b1;
          if (in_win) begin
            wea     <= 1'b1;
            addra   <= wr_addr;
            dina    <= rgb565_to_444(byte_hi, cam_byte);
            wr_addr <= wr_addr + 1'b1;
          end
        end
      end

      if (last_wr) begin
        frame_done <= 1'b1;
        frame_cnt  <= frame_cnt + 1'b1;
      end

      if ((state == ST_CAPTURE) && vs_rise && !last_wr) frame_err <= 1'b1;
    end
  end

endmodule
